// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state encoding
// and the default fairness and timeout limits.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  localparam int STARVE_LIM_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog for one memory transaction: counts busy cycles without ack and
// flags the cycle that reaches TIMEOUT-1.
module mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT - 1));

  // Holding at the expiry value keeps the counter from wrapping if the
  // owner ever lingers in a busy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port. Data has
// priority, bounded by a starvation counter; hung accesses time out.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                d_err,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic          busy;
  logic          expired;
  logic          done;
  logic          grant_d;
  logic          in_if;
  logic          in_d;

  assign busy    = (state != IDLE);
  assign in_if   = (state == BUSY_IF);
  assign in_d    = (state == BUSY_D);
  assign done    = busy & (mem_ack | expired);
  assign grant_d = d_req & ~(if_req & (starve_cnt == SW'(STARVE_LIM)));

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~busy),
    .enable  (busy & ~mem_ack),
    .expired (expired)
  );

  // An ack in the expiry cycle wins: ready with data, no error.
  assign if_ready = in_if & (mem_ack | expired);
  assign d_ready  = in_d & (mem_ack | expired);
  assign if_err   = in_if & expired & ~mem_ack;
  assign d_err    = in_d & expired & ~mem_ack;
  assign if_rdata = (in_if && mem_ack) ? mem_rdata : '0;
  assign d_rdata  = (in_d && mem_ack) ? mem_rdata : '0;
  assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            mem_cs    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            if (if_req && (starve_cnt != SW'(STARVE_LIM))) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end else if (if_req) begin
            state      <= BUSY_IF;
            mem_cs     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          // Completion is unconditional on the request still being held.
          if (done) begin
            state     <= IDLE;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SLIM   = 4;
  localparam int TOUT   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready, if_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_ready, d_err;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(SLIM), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
  endtask

  typedef struct {
    bit          fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          ack_cyc;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[7];

  task automatic run_row(input int idx, input vec_t v);
    int  bad_early = 0;
    bit  seen = 0;
    step();
    if_req = v.fetch; d_req = !v.fetch;
    if_addr = v.addr; d_addr = v.addr;
    d_we = v.we; d_wdata = v.wdata; d_be = v.be;
    mem_ack = 0; mem_rdata = v.rdata;
    #4;
    chk($sformatf("r%0d_stall_c0", idx), stall, 1);
    chk($sformatf("r%0d_cs_c0", idx), mem_cs, 0);
    for (int c = 1; c <= 20 && !seen; c++) begin
      step();
      mem_ack = (c == v.ack_cyc);
      #4;
      if (c == 1) begin
        chk($sformatf("r%0d_cs", idx), mem_cs, 1);
        chk($sformatf("r%0d_addr", idx), mem_addr, v.addr);
        chk($sformatf("r%0d_we", idx), mem_we, v.exp_we);
        chk($sformatf("r%0d_wdata", idx), mem_wdata, v.exp_wdata);
        chk($sformatf("r%0d_be", idx), mem_be, v.exp_be);
      end
      if (c == v.exp_cyc) begin
        seen = 1;
        chk($sformatf("r%0d_ready", idx), v.fetch ? if_ready : d_ready, 1);
        chk($sformatf("r%0d_err", idx), v.fetch ? if_err : d_err, v.exp_err);
        chk($sformatf("r%0d_rdata", idx), v.fetch ? if_rdata : d_rdata, v.exp_rdata);
        chk($sformatf("r%0d_other_ready", idx), v.fetch ? d_ready : if_ready, 0);
        chk($sformatf("r%0d_stall_done", idx), stall, 0);
      end else begin
        if (if_ready || d_ready || if_err || d_err || if_rdata != 0 || d_rdata != 0 ||
            !stall || !mem_cs) bad_early++;
      end
    end
    chk($sformatf("r%0d_ready_seen", idx), seen, 1);
    chk($sformatf("r%0d_early", idx), bad_early, 0);
    step();
    if_req = 0; d_req = 0; mem_ack = 0;
    #4;
    chk($sformatf("r%0d_idle_after", idx), mem_cs, 0);
  endtask

  // Transaction-level reference state for the randomized run.
  bit          m_busy, m_own_d, m_done, m_if_rdy, m_d_rdy, m_we;
  int          m_age, m_streak;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;

  initial begin
    string order;
    bit    flag;
    bit    dead;

    // ---- reset state ----
    idle_inputs();
    rst_n = 0;
    #12;
    chk("rst_cs", mem_cs, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_ready", {if_ready, d_ready, if_err, d_err}, 0);
    step(); rst_n = 1;

    // ---- directed vector table ----
    vecs[0] = '{0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,        1,  1, 0, 32'h0,        1, 32'hDEADBEEF, 4'hF};
    vecs[1] = '{1, 1, 32'h40,  32'hCAFEF00D, 4'hA, 32'h13,       3,  3, 0, 32'h13,       0, 32'h0,        4'h0};
    vecs[2] = '{1, 0, 32'h80,  32'h0,        4'h0, 32'hFFFFFFFF, 0, 16, 1, 32'h0,        0, 32'h0,        4'h0};
    vecs[3] = '{0, 0, 32'h204, 32'h55AA55AA, 4'h3, 32'h12345678, 2,  2, 0, 32'h12345678, 0, 32'h55AA55AA, 4'h3};
    vecs[4] = '{0, 1, 32'h300, 32'h11112222, 4'hC, 32'h0BADF00D, 16, 16, 0, 32'h0BADF00D, 1, 32'h11112222, 4'hC};
    vecs[5] = '{0, 0, 32'h400, 32'h0,        4'h1, 32'hA5A5A5A5, 0, 16, 1, 32'h0,        0, 32'h0,        4'h1};
    vecs[6] = '{1, 0, 32'h44,  32'h0,        4'h0, 32'h77,       15, 15, 0, 32'h77,       0, 32'h0,        4'h0};
    foreach (vecs[i]) run_row(i, vecs[i]);

    // ---- ack while idle is ignored ----
    step();
    idle_inputs();
    mem_ack = 1; mem_rdata = 32'h99;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("idle_ack_ready", {if_ready, d_ready, if_err, d_err}, 0);
      chk("idle_ack_cs", mem_cs, 0);
      step();
    end
    mem_ack = 0;

    // ---- starvation limit: D,D,D,D,IF then the pattern repeats ----
    do_reset();
    if_req = 1; if_addr = 32'h1000;
    d_req = 1; d_we = 0; d_addr = 32'h2000;
    mem_ack = 1;
    order = "";
    for (int c = 0; c < 60 && order.len() < 10; c++) begin
      #4;
      if (d_ready) order = {order, "D"};
      if (if_ready) order = {order, "I"};
      step();
    end
    n_cmp++;
    if (order != "DDDDIDDDDI") begin
      n_bad++;
      $display("FAIL starve_order: got %s want DDDDIDDDDI", order);
    end
    idle_inputs();
    step();

    // ---- reset during BUSY_D abandons, then re-grants ----
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF;
    step();
    #4;
    chk("rstmid_busy", mem_cs, 1);
    step();
    #1;
    rst_n = 0; mem_ack = 1;
    #1;
    chk("rstmid_cs", mem_cs, 0);
    chk("rstmid_ready", {d_ready, d_err}, 0);
    step();
    rst_n = 1; mem_ack = 0;
    flag = 0;
    for (int c = 0; c < 4 && !flag; c++) begin
      #4;
      if (mem_cs && mem_addr == 32'h200) flag = 1;
      if (d_ready) flag = 0;
      step();
    end
    chk("rstmid_regrant", flag, 1);
    mem_ack = 1;
    #4;
    chk("rstmid_done", d_ready, 1);
    step();
    idle_inputs();

    // ---- request dropped mid-busy still completes ----
    step();
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h1; d_be = 4'h1;
    step();
    d_req = 0;
    #4;
    chk("drop_busy", mem_cs, 1);
    chk("drop_no_ready", d_ready, 0);
    step();
    mem_ack = 1; mem_rdata = 32'h5;
    #4;
    chk("drop_ready", d_ready, 1);
    chk("drop_rdata", d_rdata, 32'h5);
    step();
    idle_inputs();

    // ---- randomized run vs transaction-level model ----
    do_reset();
    m_busy = 0; m_own_d = 0; m_done = 0; m_if_rdy = 0; m_d_rdy = 0;
    m_age = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_we = 0; m_be = '0;
    dead = 0;
    for (int n = 0; n < 800; n++) begin
      step();
      // advance the model with the inputs that were present at this edge
      if (m_busy) begin
        if (m_done) m_busy = 0;
        else m_age++;
      end else if (if_req || d_req) begin
        if (d_req && !(if_req && m_streak == SLIM)) begin
          m_own_d = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_be = d_be;
          if (if_req && m_streak < SLIM) m_streak++;
        end else begin
          m_own_d = 0; m_addr = if_addr; m_we = 0; m_wdata = '0; m_be = '0;
          m_streak = 0;
        end
        m_busy = 1; m_age = 1;
      end
      // requesters hold until their ready, then may re-issue
      if (!if_req || m_if_rdy) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
      end
      if (!d_req || m_d_rdy) begin
        d_req = ($urandom_range(0, 1) == 0);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom;
        d_wdata = $urandom;
        d_be = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 40) == 0) dead = !dead;
      mem_ack = dead ? 1'b0 : ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      m_done = m_busy && (mem_ack || m_age == TOUT);
      m_if_rdy = m_done && !m_own_d;
      m_d_rdy = m_done && m_own_d;
      #4;
      chk("rnd_cs", mem_cs, m_busy);
      chk("rnd_if_ready", if_ready, m_if_rdy);
      chk("rnd_d_ready", d_ready, m_d_rdy);
      chk("rnd_if_err", if_err, m_if_rdy && !mem_ack);
      chk("rnd_d_err", d_err, m_d_rdy && !mem_ack);
      chk("rnd_if_rdata", if_rdata, (m_if_rdy && mem_ack) ? mem_rdata : 32'h0);
      chk("rnd_d_rdata", d_rdata, (m_d_rdy && mem_ack) ? mem_rdata : 32'h0);
      chk("rnd_stall", stall, (if_req && !m_if_rdy) || (d_req && !m_d_rdy));
      if (m_busy) begin
        chk("rnd_addr", mem_addr, m_addr);
        chk("rnd_we", mem_we, m_we);
        chk("rnd_wdata", mem_wdata, m_wdata);
        chk("rnd_be", mem_be, m_be);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
